// File: rtl/updown_counter_param_if.sv
// Control and status bundle for updown_counter_param.
// The master drives the controls and the slave is the counter itself.
interface updown_counter_param_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] counter;
  logic             at_zero;
  logic             at_max;
  logic             wrap_pulse;
  logic             limit_hit;

  modport master (
    output en, up_dn, load, load_value,
    input  counter, at_zero, at_max, wrap_pulse, limit_hit
  );

  modport slave (
    input  en, up_dn, load, load_value,
    output counter, at_zero, at_max, wrap_pulse, limit_hit
  );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down tick counter with prescaler, clamped load,
// wrap or saturate limits and registered wrap/limit event pulses.
module updown_counter_param #(
  parameter int WIDTH       = 4,
  parameter int MOD_MAX     = 15,
  parameter int PRESCALE    = 1,
  parameter bit SATURATE    = 1'b0,
  parameter int RESET_VALUE = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  updown_counter_param_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] RST_V      = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ZERO_V     = '0;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             wrap_q, wrap_d;
  logic             limit_q, limit_d;
  logic             step;

  assign step = bus.en && (presc_q == PRESC_LAST);

  // NOTE: every output of this block gets a default first so that no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    limit_d = 1'b0;

    if (bus.load) begin
      count_d = (bus.load_value > MAX_V) ? MAX_V : bus.load_value;
      presc_d = '0;
    end else if (bus.en) begin
      if (step) begin
        presc_d = '0;
        if (bus.up_dn) begin
          if (count_q != MAX_V) begin
            count_d = count_q + WIDTH'(1);
          end else if (SATURATE) begin
            limit_d = 1'b1;
          end else begin
            count_d = ZERO_V;
            wrap_d  = 1'b1;
          end
        end else begin
          if (count_q != ZERO_V) begin
            count_d = count_q - WIDTH'(1);
          end else if (SATURATE) begin
            limit_d = 1'b1;
          end else begin
            count_d = MAX_V;
            wrap_d  = 1'b1;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= RST_V;
      presc_q <= '0;
      wrap_q  <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      limit_q <= limit_d;
    end
  end

  assign bus.counter    = count_q;
  assign bus.at_zero    = (count_q == ZERO_V);
  assign bus.at_max     = (count_q == MAX_V);
  assign bus.wrap_pulse = wrap_q;
  assign bus.limit_hit  = limit_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: four parameterisations share one
// clock and reset, each driven through its own interface instance.
module tb_updown_counter_param;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  updown_counter_param_if #(.WIDTH(4)) if_def ();
  updown_counter_param_if #(.WIDTH(4)) if_m9  ();
  updown_counter_param_if #(.WIDTH(4)) if_sat ();
  updown_counter_param_if #(.WIDTH(4)) if_pre ();

  updown_counter_param u_def (.clk(clk), .reset(reset), .bus(if_def.slave));

  updown_counter_param #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(1), .SATURATE(1'b0), .RESET_VALUE(0))
    u_m9 (.clk(clk), .reset(reset), .bus(if_m9.slave));

  updown_counter_param #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(1), .SATURATE(1'b1), .RESET_VALUE(0))
    u_sat (.clk(clk), .reset(reset), .bus(if_sat.slave));

  updown_counter_param #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(3), .SATURATE(1'b0), .RESET_VALUE(9))
    u_pre (.clk(clk), .reset(reset), .bus(if_pre.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge and outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    checks++; if (if_def.counter !== 4'd15) begin errors++; $display("FAIL reset_def: counter=%0d expected 15", if_def.counter); end
    checks++; if (if_def.at_max !== 1'b1) begin errors++; $display("FAIL reset_def_at_max: got %b expected 1", if_def.at_max); end
    checks++; if (if_m9.counter !== 4'd0 || if_m9.at_zero !== 1'b1) begin errors++; $display("FAIL reset_m9: counter=%0d at_zero=%b expected 0/1", if_m9.counter, if_m9.at_zero); end
    checks++; if (if_sat.counter !== 4'd0) begin errors++; $display("FAIL reset_sat: counter=%0d expected 0", if_sat.counter); end
    checks++; if (if_pre.counter !== 4'd9) begin errors++; $display("FAIL reset_pre: counter=%0d expected 9", if_pre.counter); end
    checks++; if (if_def.wrap_pulse !== 1'b0 || if_def.limit_hit !== 1'b0) begin errors++; $display("FAIL reset_pulses: wrap=%b limit=%b expected 0/0", if_def.wrap_pulse, if_def.limit_hit); end
    reset = 1'b1;
  endtask

  task automatic test_legacy_down();
    logic [3:0] exp_cnt;
    if_def.en = 1'b1; if_def.up_dn = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      exp_cnt = 4'((15 - i + 32) % 16);
      checks++; if (if_def.counter !== exp_cnt) begin errors++; $display("FAIL down_cnt[%0d]: counter=%0d expected %0d", i, if_def.counter, exp_cnt); end
      checks++; if (if_def.wrap_pulse !== (i == 16)) begin errors++; $display("FAIL down_wrap[%0d]: wrap=%b expected %b", i, if_def.wrap_pulse, (i == 16)); end
      checks++; if (if_def.at_zero !== (exp_cnt == 4'd0)) begin errors++; $display("FAIL down_at_zero[%0d]: got %b expected %b", i, if_def.at_zero, (exp_cnt == 4'd0)); end
    end
    if_def.en = 1'b0;
  endtask

  task automatic test_mod9_up();
    logic [3:0] exp_cnt;
    if_m9.en = 1'b1; if_m9.up_dn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_cnt = 4'(i % 10);
      checks++; if (if_m9.counter !== exp_cnt) begin errors++; $display("FAIL mod9_cnt[%0d]: counter=%0d expected %0d", i, if_m9.counter, exp_cnt); end
      checks++; if (if_m9.wrap_pulse !== (i == 10)) begin errors++; $display("FAIL mod9_wrap[%0d]: wrap=%b expected %b", i, if_m9.wrap_pulse, (i == 10)); end
      checks++; if (if_m9.at_max !== (exp_cnt == 4'd9)) begin errors++; $display("FAIL mod9_at_max[%0d]: got %b expected %b", i, if_m9.at_max, (exp_cnt == 4'd9)); end
    end
    if_m9.en = 1'b0;
  endtask

  task automatic test_saturate();
    logic [3:0] exp_up  [3] = '{4'd9, 4'd9, 4'd9};
    logic       lim_up  [3] = '{1'b0, 1'b1, 1'b1};
    logic       lim_dn  [2] = '{1'b0, 1'b1};
    if_sat.load = 1'b1; if_sat.load_value = 4'd8;
    tick();
    checks++; if (if_sat.counter !== 4'd8) begin errors++; $display("FAIL sat_load8: counter=%0d expected 8", if_sat.counter); end
    if_sat.load = 1'b0; if_sat.en = 1'b1; if_sat.up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if_sat.counter !== exp_up[i] || if_sat.limit_hit !== lim_up[i] || if_sat.wrap_pulse !== 1'b0) begin
        errors++; $display("FAIL sat_up[%0d]: counter=%0d limit=%b wrap=%b expected %0d/%b/0", i, if_sat.counter, if_sat.limit_hit, if_sat.wrap_pulse, exp_up[i], lim_up[i]);
      end
    end
    if_sat.en = 1'b0; if_sat.load = 1'b1; if_sat.load_value = 4'd1;
    tick();
    checks++; if (if_sat.counter !== 4'd1 || if_sat.limit_hit !== 1'b0) begin errors++; $display("FAIL sat_load1: counter=%0d limit=%b expected 1/0", if_sat.counter, if_sat.limit_hit); end
    if_sat.load = 1'b0; if_sat.en = 1'b1; if_sat.up_dn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (if_sat.counter !== 4'd0 || if_sat.limit_hit !== lim_dn[i] || if_sat.wrap_pulse !== 1'b0) begin
        errors++; $display("FAIL sat_dn[%0d]: counter=%0d limit=%b wrap=%b expected 0/%b/0", i, if_sat.counter, if_sat.limit_hit, if_sat.wrap_pulse, lim_dn[i]);
      end
    end
    if_sat.en = 1'b0;
    tick();
    checks++; if (if_sat.limit_hit !== 1'b0) begin errors++; $display("FAIL sat_pulse_drop: limit=%b expected 0", if_sat.limit_hit); end
  endtask

  task automatic test_prescale();
    logic       en_seq  [11] = '{1,1,1,1,1,1,1,0,0,1,1};
    logic [3:0] exp_seq [11] = '{5,5,6,6,6,7,7,7,7,7,8};
    if_pre.load = 1'b1; if_pre.load_value = 4'd5;
    tick();
    checks++; if (if_pre.counter !== 4'd5) begin errors++; $display("FAIL pre_load: counter=%0d expected 5", if_pre.counter); end
    if_pre.load = 1'b0; if_pre.up_dn = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if_pre.en = en_seq[i];
      tick();
      checks++; if (if_pre.counter !== exp_seq[i]) begin errors++; $display("FAIL pre_seq[%0d]: counter=%0d expected %0d", i, if_pre.counter, exp_seq[i]); end
    end
    if_pre.en = 1'b0;
  endtask

  task automatic test_load();
    if_m9.load = 1'b1; if_m9.load_value = 4'd13;
    tick();
    checks++; if (if_m9.counter !== 4'd9 || if_m9.at_max !== 1'b1) begin errors++; $display("FAIL load_clamp: counter=%0d at_max=%b expected 9/1", if_m9.counter, if_m9.at_max); end
    if_m9.en = 1'b1; if_m9.up_dn = 1'b1; if_m9.load_value = 4'd4;
    tick();
    checks++; if (if_m9.counter !== 4'd4 || if_m9.wrap_pulse !== 1'b0) begin errors++; $display("FAIL load_beats_step: counter=%0d wrap=%b expected 4/0", if_m9.counter, if_m9.wrap_pulse); end
    if_m9.load = 1'b0; if_m9.en = 1'b0;

    // Prescaler instance sits at 8 with phase 0; advance two phases then load.
    if_pre.en = 1'b1; if_pre.up_dn = 1'b1;
    tick(); tick();
    checks++; if (if_pre.counter !== 4'd8) begin errors++; $display("FAIL load_pre_hold: counter=%0d expected 8", if_pre.counter); end
    if_pre.load = 1'b1; if_pre.load_value = 4'd2;
    tick();
    checks++; if (if_pre.counter !== 4'd2 || if_pre.wrap_pulse !== 1'b0) begin errors++; $display("FAIL load_pre: counter=%0d wrap=%b expected 2/0", if_pre.counter, if_pre.wrap_pulse); end
    if_pre.load = 1'b0;
    tick(); tick();
    checks++; if (if_pre.counter !== 4'd2) begin errors++; $display("FAIL load_phase_reset: counter=%0d expected 2", if_pre.counter); end
    tick();
    checks++; if (if_pre.counter !== 4'd3) begin errors++; $display("FAIL load_phase_step: counter=%0d expected 3", if_pre.counter); end
  endtask

  task automatic test_reset_midcount();
    logic [3:0] exp_seq  [3] = '{9, 9, 0};
    logic       wrap_seq [3] = '{0, 0, 1};
    tick();  // prescaler phase now 1, counter still 3
    checks++; if (if_pre.counter !== 4'd3) begin errors++; $display("FAIL mid_pre: counter=%0d expected 3", if_pre.counter); end
    reset = 1'b0; if_pre.load = 1'b1; if_pre.load_value = 4'd5;
    tick();
    checks++; if (if_pre.counter !== 4'd9 || if_pre.wrap_pulse !== 1'b0 || if_pre.limit_hit !== 1'b0) begin
      errors++; $display("FAIL mid_reset: counter=%0d wrap=%b limit=%b expected 9/0/0", if_pre.counter, if_pre.wrap_pulse, if_pre.limit_hit);
    end
    reset = 1'b1; if_pre.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if_pre.counter !== exp_seq[i] || if_pre.wrap_pulse !== wrap_seq[i]) begin
        errors++; $display("FAIL mid_after[%0d]: counter=%0d wrap=%b expected %0d/%b", i, if_pre.counter, if_pre.wrap_pulse, exp_seq[i], wrap_seq[i]);
      end
    end
    if_pre.en = 1'b0;
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    tick();
    checks++; if (if_pre.counter !== 4'd0 || if_pre.wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_glitch: counter=%0d wrap=%b expected 0/0", if_pre.counter, if_pre.wrap_pulse); end
  endtask

  initial begin
    reset = 1'b0;
    if_def.en = 1'b0; if_def.up_dn = 1'b0; if_def.load = 1'b0; if_def.load_value = '0;
    if_m9.en  = 1'b0; if_m9.up_dn  = 1'b0; if_m9.load  = 1'b0; if_m9.load_value  = '0;
    if_sat.en = 1'b0; if_sat.up_dn = 1'b0; if_sat.load = 1'b0; if_sat.load_value = '0;
    if_pre.en = 1'b0; if_pre.up_dn = 1'b0; if_pre.load = 1'b0; if_pre.load_value = '0;
    #1;
    test_reset();
    test_legacy_down();
    test_mod9_up();
    test_saturate();
    test_prescale();
    test_load();
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
